bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It converts a binary value, such as the 14-bit answer, the timer count or the score, into decimal digits for the hex_decoder displays. It is the inverse of the existing digit-entry path, which builds a binary value from decimal digits, and it replaces the combinational / and % operators in the display path. It uses a single-request start/done handshake with one bit processed per clock.

---
 rtl/bcd_pkg.sv | 35 +++
 rtl/bcd_add3.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 146 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Contents: FSM state enum, nibble width, add-3 threshold, and the
// parameter legality check used at elaboration of bin_to_bcd_seq.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam int unsigned NIBBLE_W    = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;

  // True when in_w is in 1..32 and 10^digits exceeds the largest in_w-bit value.
  function automatic bit bcd_params_ok(input int unsigned in_w, input int unsigned digits);
    longint unsigned max_v;
    longint unsigned pow10;
    bit              ok;
    ok    = 1'b0;
    pow10 = 64'd1;
    max_v = 64'd0;
    if (in_w >= 1 && in_w <= 32) begin
      max_v = (64'd1 << in_w) - 64'd1;
      for (int unsigned i = 0; i < digits; i++) begin
        if (!ok) begin
          pow10 = pow10 * 64'd10;
          if (pow10 > max_v) ok = 1'b1;
        end
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble nibble adjust: nibbles of 5 or more get 3 added.
// Ports:
//   nib_i  BCD nibble before the shift
//   nib_o  adjusted nibble
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nib_i,
  output logic [NIBBLE_W-1:0] nib_o
);

  assign nib_o = (nib_i >= ADD3_THRESH) ? NIBBLE_W'(nib_i + NIBBLE_W'(3)) : nib_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A start seen in IDLE captures bin_in; IN_W shift cycles later a one-cycle
// done pulse coincides with the new bcd_out/blank values, which then hold.
// Ports:
//   clk, resetn   clock and synchronous active-low reset
//   start         conversion request, sampled only in IDLE
//   bin_in        binary value captured on the accepted start edge
//   busy          high while shifting
//   done          one-cycle completion pulse
//   bcd_out       result, digit k in bits [4k+3:4k], k=0 is the ones digit
//   blank         leading-zero mask, bit k set when digit k is a leading zero
// Build option: define BIN_TO_BCD_LZB_EN to generate the blank mask;
// otherwise blank is tied to zero.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W   = 14,
  parameter int unsigned DIGITS = 5
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [IN_W-1:0]            bin_in,
  output logic                       busy,
  output logic                       done,
  output logic [NIBBLE_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]          blank
);

  localparam int unsigned BCD_W = NIBBLE_W * DIGITS;
  localparam int unsigned SW    = BCD_W + IN_W;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  // Refuse to elaborate when DIGITS cannot hold the largest IN_W-bit value.
  generate
    if (!bcd_params_ok(IN_W, DIGITS)) begin : g_param_check
      $error("bin_to_bcd_seq: illegal IN_W/DIGITS combination");
    end
  endgenerate

  bcd_state_e       state_q, state_d;
  logic [SW-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             busy_q, done_q;
  logic [SW-1:0]    adj;
  logic [SW-1:0]    shifted;

  // Add-3 on every BCD nibble in parallel; the binary field passes through.
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .nib_i (scratch_q[IN_W+NIBBLE_W*g +: NIBBLE_W]),
        .nib_o (adj[IN_W+NIBBLE_W*g +: NIBBLE_W])
      );
    end
  endgenerate

  assign adj[IN_W-1:0] = scratch_q[IN_W-1:0];
  assign shifted       = adj << 1;

`ifdef BIN_TO_BCD_LZB_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] lzb_new;
  logic              zero_above;

  // Digit k (k>=1) is blank when it and every digit above it are zero.
  always_comb begin
    lzb_new    = '0;
    zero_above = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_above = zero_above & (shifted[IN_W+NIBBLE_W*k +: NIBBLE_W] == NIBBLE_W'(0));
      lzb_new[k] = zero_above;
    end
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
`ifdef BIN_TO_BCD_LZB_EN
    blank_d   = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          scratch_d = SW'(bin_in);
          cnt_d     = CNT_W'(IN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        cnt_d     = cnt_q - CNT_W'(1);
        // Last shift: results are registered so they appear with done.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          bcd_d   = shifted[SW-1:IN_W];
`ifdef BIN_TO_BCD_LZB_EN
          blank_d = lzb_new;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BIN_TO_BCD_LZB_EN
      blank_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      busy_q    <= (state_d == SHIFT);
      done_q    <= (state_d == DONE);
`ifdef BIN_TO_BCD_LZB_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
`ifdef BIN_TO_BCD_LZB_EN
  assign blank   = blank_q;
`else
  assign blank   = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: default 14-bit/5-digit instance
// compared every cycle against a decimal-arithmetic reference, plus a
// 7-bit/3-digit instance swept over its full input range.
module tb_bin_to_bcd_seq;

  localparam int unsigned IN_W   = 14;
  localparam int unsigned DIGITS = 5;
`ifdef BIN_TO_BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, start;
  logic [13:0] bin_in;
  logic        busy, done;
  logic [19:0] bcd_out;
  logic [4:0]  blank;

  logic        start7;
  logic [6:0]  bin7;
  logic        busy7, done7;
  logic [11:0] bcd7;
  logic [2:0]  blank7;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.IN_W(14), .DIGITS(5)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .blank(blank)
  );

  bin_to_bcd_seq #(.IN_W(7), .DIGITS(3)) u_dut7 (
    .clk(clk), .resetn(resetn), .start(start7), .bin_in(bin7),
    .busy(busy7), .done(done7), .bcd_out(bcd7), .blank(blank7)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of v, packed 4 bits per digit, ones digit lowest.
  function automatic logic [63:0] dec_bcd(input longint unsigned v, input int unsigned nd);
    logic [63:0]     r;
    longint unsigned t;
    r = '0;
    t = v;
    for (int k = 0; k < nd; k++) begin
      r = r | (64'(t % 10) << (4 * k));
      t = t / 10;
    end
    return r;
  endfunction

  // Digit k>=1 is a leading zero exactly when v < 10^k.
  function automatic logic [63:0] lz_mask(input longint unsigned v, input int unsigned nd);
    logic [63:0]     r;
    longint unsigned p;
    r = '0;
    p = 1;
    for (int k = 1; k < nd; k++) begin
      p = p * 10;
      if (v < p) r[k] = 1'b1;
    end
    return LZB ? r : 64'd0;
  endfunction

  // Reference model: cycle-indexed view of request acceptance and completion.
  int              n       = 0;
  int              acc     = 0;
  int              next_ok = 0;
  bit              pend    = 1'b0;
  longint unsigned pv      = 0;
  logic            m_busy  = 1'b0;
  logic            m_done  = 1'b0;
  logic [63:0]     m_bcd   = '0;
  logic [63:0]     m_blank = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (!resetn) begin
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_bcd   = '0;
        m_blank = '0;
        pend    = 1'b0;
        next_ok = n + 1;
      end else begin
        if (!pend && n >= next_ok && start) begin
          acc     = n;
          pend    = 1'b1;
          pv      = longint'(bin_in);
          next_ok = n + int'(IN_W) + 2;
        end
        m_busy = pend && (n <= acc + int'(IN_W) - 1);
        m_done = 1'b0;
        if (pend && n == acc + int'(IN_W)) begin
          m_done  = 1'b1;
          m_bcd   = dec_bcd(pv, DIGITS);
          m_blank = lz_mask(pv, DIGITS);
          pend    = 1'b0;
        end
      end
      n++;
      @(negedge clk);
      chk("cyc_busy", 64'(busy), 64'(m_busy));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_bcd", 64'(bcd_out), m_bcd);
      chk("cyc_blank", 64'(blank), m_blank);
    end
  end

  // One request; reports latency (negedges after the accept edge), busy and done widths.
  task automatic conv(input logic [13:0] v, output int lat, output int bcyc, output int dcyc);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 14'($urandom);
    lat  = 0;
    bcyc = 0;
    dcyc = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) bcyc++;
      if (done) begin
        dcyc++;
        if (lat == 0) lat = i;
      end
      if (lat != 0 && !done) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bcyc, dcyc, dcount;
    logic [13:0] v;
    resetn = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    start7 = 1'b0;
    bin7   = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd_out), 64'd0);
    chk("rst_blank", 64'(blank), 64'd0);
    chk("model_12345", dec_bcd(12345, 5), 64'h12345);

    conv(14'd0, lat, bcyc, dcyc);
    chk("zero_latency", 64'(lat), 64'd15);
    chk("zero_bcd", 64'(bcd_out), 64'h00000);
    chk("zero_blank", 64'(blank), LZB ? 64'b11110 : 64'd0);

    conv(14'd9999, lat, bcyc, dcyc);
    chk("9999_bcd", 64'(bcd_out), 64'h09999);
    chk("9999_blank", 64'(blank), LZB ? 64'b10000 : 64'd0);
    chk("9999_busy_cycles", 64'(bcyc), 64'd14);
    chk("9999_done_cycles", 64'(dcyc), 64'd1);

    conv(14'd16383, lat, bcyc, dcyc);
    chk("max_bcd", 64'(bcd_out), 64'h16383);
    chk("max_blank", 64'(blank), 64'd0);
    conv(14'd42, lat, bcyc, dcyc);
    chk("42_bcd", 64'(bcd_out), 64'h00042);
    chk("42_blank", 64'(blank), LZB ? 64'b11100 : 64'd0);

    // start held high, bin_in changed mid-conversion
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd5000;
    dcount = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5) bin_in = 14'd1234;
      if (done) dcount++;
      if (i == 15) chk("held_first", 64'(bcd_out), 64'h05000);
      if (i == 31) chk("held_second", 64'(bcd_out), 64'h01234);
    end
    chk("held_done_count", 64'(dcount), 64'd2);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // reset in the 7th shift cycle aborts the conversion
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd5555;
    @(negedge clk);
    start  = 1'b0;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_bcd", 64'(bcd_out), 64'd0);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    conv(14'd5555, lat, bcyc, dcyc);
    chk("after_abort_bcd", 64'(bcd_out), 64'h05555);

    repeat (25) begin
      v = 14'($urandom_range(0, 16383));
      conv(v, lat, bcyc, dcyc);
      chk("rand_latency", 64'(lat), 64'd15);
      chk("rand_bcd", 64'(bcd_out), dec_bcd(longint'(v), 5));
    end

    // 7-bit / 3-digit instance: full sweep
    for (int s = 0; s < 128; s++) begin
      @(negedge clk);
      start7 = 1'b1;
      bin7   = 7'(s);
      @(negedge clk);
      start7 = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        if (done7) begin
          lat = i;
          break;
        end
        @(negedge clk);
      end
      chk("sweep_latency", 64'(lat), 64'd8);
      chk("sweep_bcd", 64'(bcd7), dec_bcd(longint'(s), 3));
      chk("sweep_blank", 64'(blank7), lz_mask(longint'(s), 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
